led_burst_scheduler: RTL

//  Shares the 10-bit LED bank between NREQ game-event requesters (e.g. win, lose, hit).

---
 rtl/led_burst_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/led_burst_scheduler.sv
// led_burst_scheduler: arbitrates LED-bank requests and runs one timed blink burst per grant.
// Define LED_RR_ARB_EN for round-robin arbitration; the default build uses fixed priority (lowest index).
module led_burst_scheduler #(
  parameter int NREQ     = 3,
  parameter int LEDW     = 10,
  parameter int TICK_DIV = 25_000_000,
  parameter int BURST    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LEDW-1:0] pat,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 done,
  output logic                 tick,
  output logic [LEDW-1:0]      leds
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(BURST + 1);
  localparam int IW = $clog2(NREQ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]   presc;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [LEDW-1:0] pat_q;
  logic            on_phase;
  logic            owner_req;
  logic            phase_end;
  logic            last_tick;

  assign owner_req = req[owner];
  assign phase_end = (presc == PRESC_MAX);
  assign last_tick = phase_end && (cnt == CNT_LAST);

`ifdef LED_RR_ARB_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // Scanning from the far end keeps the hit closest to ptr as the final winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (state == RUN && (!owner_req || last_tick))
      ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win     = IW'(k);
        win_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Abort is tested before the tick so a dropped request wins even on the final phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = RUN;
      RUN:     if (!owner_req)    state_nxt = IDLE;
               else if (last_tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      cnt      <= '0;
      owner    <= '0;
      pat_q    <= '0;
      on_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          owner    <= win;
          pat_q    <= pat[win*LEDW +: LEDW];
          presc    <= '0;
          cnt      <= '0;
          on_phase <= 1'b1;
        end
        RUN: if (phase_end) begin
          presc    <= '0;
          cnt      <= cnt + 1'b1;
          on_phase <= ~on_phase;
        end else begin
          presc    <= presc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    busy  = 1'b0;
    done  = 1'b0;
    tick  = 1'b0;
    leds  = '0;
    case (state)
      RUN: begin
        grant[owner] = 1'b1;
        busy         = 1'b1;
        tick         = phase_end && owner_req;
        leds         = on_phase ? pat_q : '0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
